// File: rtl/sync_pkg.sv
// Shared types and default rates for the SYNC0-locked ultrasound time base.
package sync_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } sync_state_t;

    localparam int SYS_CLK_FREQ_DEF    = 20480000;
    localparam int ULTRASOUND_FREQ_DEF = 40000;
    localparam int SYNC0_FREQ_DEF      = 2000;

    localparam int DEFAULT_CYCLE = SYS_CLK_FREQ_DEF / ULTRASOUND_FREQ_DEF;
    localparam int SYNC_PERIOD   = SYS_CLK_FREQ_DEF / SYNC0_FREQ_DEF;

    // The period counter must reach 2*SYNC_PERIOD to detect a lost SYNC train.
    function automatic int period_width(input int sync_period);
        return $clog2(2 * sync_period + 1);
    endfunction

    localparam int PERIOD_W = period_width(SYNC_PERIOD);

endpackage

// File: rtl/sync_time_base_if.sv
// Bus bundle between the SYNC/configuration source and the time base outputs.
interface sync_time_base_if #(
    parameter int CYCLE_WIDTH   = 16,
    parameter int REF_CNT_WIDTH = 8
);
    // SYNC is a single-cycle strobe with no back-pressure; CYCLE and REF_CYCLE
    // are level inputs sampled only on SYNC or on a cycle wrap.
    logic                             SYNC;
    logic [CYCLE_WIDTH-1:0]           CYCLE;
    logic [REF_CNT_WIDTH-1:0]         REF_CYCLE;
    logic [CYCLE_WIDTH-1:0]           TIME;
    logic                             UPDATE;
    logic                             REF_CLK_TICK;
    logic [REF_CNT_WIDTH-1:0]         REF_CLK_CNT;
    logic                             LOCKED;
    logic [7:0]                       SYNC_ERR_CNT;
    logic signed [CYCLE_WIDTH:0]      PHASE_ERR;
    sync_pkg::sync_state_t            dbg_state;

    modport master (
        output SYNC, CYCLE, REF_CYCLE,
        input  TIME, UPDATE, REF_CLK_TICK, REF_CLK_CNT, LOCKED, SYNC_ERR_CNT,
               PHASE_ERR, dbg_state
    );

    modport slave (
        input  SYNC, CYCLE, REF_CYCLE,
        output TIME, UPDATE, REF_CLK_TICK, REF_CLK_CNT, LOCKED, SYNC_ERR_CNT,
               PHASE_ERR, dbg_state
    );

endinterface

// File: rtl/sync_period_monitor.sv
// SYNC period monitor: measures SYNC spacing, runs the lock FSM, counts lock losses.
module sync_period_monitor
    import sync_pkg::*;
#(
    parameter int SYNC_PER   = SYNC_PERIOD,
    parameter int SYNC_TOL   = 4,
    parameter int LOCK_COUNT = 3,
    parameter int PW         = period_width(SYNC_PER)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sync,
    output logic        locked,
    output logic [7:0]  sync_err_cnt,
    output sync_state_t state
);

    localparam int GW = $clog2(LOCK_COUNT + 1);

    logic [PW-1:0] period_cnt;
    sync_state_t   state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic          good_sync;
    logic          timeout;
    logic          err_inc;

    assign good_sync = (period_cnt >= PW'(SYNC_PER - SYNC_TOL)) &&
                       (period_cnt <= PW'(SYNC_PER + SYNC_TOL));
    assign timeout   = (period_cnt == PW'(2 * SYNC_PER));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (sync) begin
            period_cnt <= PW'(1);
        end else if (period_cnt != '1) begin
            period_cnt <= period_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= UNLOCKED;
            good_q       <= '0;
            sync_err_cnt <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            if (err_inc && (sync_err_cnt != 8'hFF)) begin
                sync_err_cnt <= sync_err_cnt + 8'd1;
            end
        end
    end

    // The first SYNC after UNLOCKED only starts the measurement window.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_inc = 1'b0;
        case (state_q)
            UNLOCKED: begin
                if (sync) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (sync) begin
                    if (!good_sync) begin
                        good_d = '0;
                    end else if (good_q == GW'(LOCK_COUNT - 1)) begin
                        state_d = LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + GW'(1);
                    end
                end
            end
            LOCKED: begin
                if (sync) begin
                    if (!good_sync) begin
                        state_d = ACQUIRE;
                        good_d  = '0;
                        err_inc = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = UNLOCKED;
                    err_inc = 1'b1;
                end
            end
            default: begin
                state_d = UNLOCKED;
                good_d  = '0;
            end
        endcase
    end

    always_comb begin
        locked = (state_q == LOCKED);
        state  = state_q;
    end

endmodule

// File: rtl/sync_time_base.sv
// Ultrasound time base locked to SYNC0: shadowed cycle/ref registers, TIME and
// reference counters, period monitor. Optional phase capture: `SYNC_PHASE_ERR_EN.
module sync_time_base
    import sync_pkg::*;
#(
    parameter int SYS_CLK_FREQ    = SYS_CLK_FREQ_DEF,
    parameter int ULTRASOUND_FREQ = ULTRASOUND_FREQ_DEF,
    parameter int SYNC0_FREQ      = SYNC0_FREQ_DEF,
    parameter int CYCLE_WIDTH     = 16,
    parameter int REF_CNT_WIDTH   = 8,
    parameter int SYNC_TOL        = 4,
    parameter int LOCK_COUNT      = 3
) (
    input logic             CLK,
    input logic             RST,
    sync_time_base_if.slave bus
);

    localparam int CW       = CYCLE_WIDTH;
    localparam int RW       = REF_CNT_WIDTH;
    localparam int CYC_RST  = SYS_CLK_FREQ / ULTRASOUND_FREQ;
    localparam int SYNC_PER = SYS_CLK_FREQ / SYNC0_FREQ;

    logic [CW-1:0] cycle_q;
    logic [CW-1:0] time_q;
    logic [RW-1:0] ref_cycle_q;
    logic [RW-1:0] ref_cnt_q;
    logic          tick_q;
    logic          wrap;
    logic          load;

    assign wrap = (time_q == cycle_q - CW'(1));
    assign load = bus.SYNC | wrap;

    // Shadow registers only change at a boundary, so TIME never overruns cycle_q.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cycle_q     <= CW'(CYC_RST);
            ref_cycle_q <= RW'(1);
        end else if (load) begin
            cycle_q     <= (bus.CYCLE < CW'(2)) ? CW'(2) : bus.CYCLE;
            ref_cycle_q <= (bus.REF_CYCLE == '0) ? RW'(1) : bus.REF_CYCLE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            time_q    <= '0;
            ref_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            time_q <= load ? '0 : time_q + CW'(1);
            tick_q <= wrap & ~bus.SYNC;
            if (bus.SYNC) begin
                ref_cnt_q <= '0;
            end else if (wrap) begin
                ref_cnt_q <= (ref_cnt_q == ref_cycle_q - RW'(1)) ? '0 : ref_cnt_q + RW'(1);
            end
        end
    end

    assign bus.TIME         = time_q;
    assign bus.UPDATE       = load;
    assign bus.REF_CLK_TICK = tick_q;
    assign bus.REF_CLK_CNT  = ref_cnt_q;

`ifdef SYNC_PHASE_ERR_EN
    localparam int PEW = CW + 1;

    logic [PEW-1:0]        cyc_ext;
    logic [PEW-1:0]        next_pos;
    logic [PEW-1:0]        phase_v;
    logic signed [PEW-1:0] phase_d;
    logic signed [PEW-1:0] phase_q;

    // Position the counter would reach on this edge, folded into a signed
    // error centred on the cycle boundary.
    always_comb begin
        cyc_ext  = {1'b0, cycle_q};
        next_pos = {1'b0, time_q} + PEW'(1);
        phase_v  = (next_pos >= cyc_ext) ? next_pos - cyc_ext : next_pos;
        phase_d  = (phase_v <= (cyc_ext >> 1)) ? $signed(phase_v)
                                                : $signed(phase_v - cyc_ext);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase_q <= '0;
        end else if (bus.SYNC) begin
            phase_q <= phase_d;
        end
    end

    assign bus.PHASE_ERR = phase_q;
`else
    assign bus.PHASE_ERR = '0;
`endif

    sync_period_monitor #(
        .SYNC_PER   (SYNC_PER),
        .SYNC_TOL   (SYNC_TOL),
        .LOCK_COUNT (LOCK_COUNT),
        .PW         (period_width(SYNC_PER))
    ) u_monitor (
        .clk          (CLK),
        .rst          (RST),
        .sync         (bus.SYNC),
        .locked       (bus.LOCKED),
        .sync_err_cnt (bus.SYNC_ERR_CNT),
        .state        (bus.dbg_state)
    );

endmodule
